// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: mode constant sets, sync polarity encoding,
// the axis-total helper and the colour-bar table used by the test pattern.
package vga_timing_pkg;

  typedef struct packed {
    logic [31:0] pixel_clk_khz;
    logic [15:0] h_vis, h_fp, h_sp, h_bp;
    logic [15:0] v_vis, v_fp, v_sp, v_bp;
    logic        hsync_pol;
    logic        vsync_pol;
  } vga_mode_t;

  // Polarity parameter encoding: the value is also the idle level of the pin.
  localparam logic SYNC_POS = 1'b0;
  localparam logic SYNC_NEG = 1'b1;

  localparam vga_mode_t SVGA_800x600_60 = '{
    pixel_clk_khz: 32'd40000,
    h_vis: 16'd800, h_fp: 16'd40, h_sp: 16'd128, h_bp: 16'd88,
    v_vis: 16'd600, v_fp: 16'd1,  v_sp: 16'd4,   v_bp: 16'd23,
    hsync_pol: SYNC_POS, vsync_pol: SYNC_POS
  };

  localparam vga_mode_t VESA_800x600_72 = '{
    pixel_clk_khz: 32'd50000,
    h_vis: 16'd800, h_fp: 16'd56, h_sp: 16'd120, h_bp: 16'd64,
    v_vis: 16'd600, v_fp: 16'd37, v_sp: 16'd6,   v_bp: 16'd23,
    hsync_pol: SYNC_POS, vsync_pol: SYNC_POS
  };

  function automatic int unsigned axis_total(input int unsigned vis,
                                             input int unsigned fp,
                                             input int unsigned sp,
                                             input int unsigned bp);
    return vis + fp + sp + bp;
  endfunction

  // 12-bit {R,G,B} per bar, index 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay with asynchronous active-low reset to a given
// value; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned           WIDTH       = 1,
  parameter int unsigned           DEPTH       = 0,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, rst_n};
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stages[i] <= RESET_VALUE;
        end
      end else begin
        stages[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stages[i] <= stages[i-1];
        end
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with aligned output delay line.
// Define VGA_TIMING_TEST_PATTERN_EN to add VGA_R/G/B colour-bar outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE_AREA = int'(SVGA_800x600_60.h_vis),
  parameter int unsigned H_FRONT_PORCH  = int'(SVGA_800x600_60.h_fp),
  parameter int unsigned H_SYNC_PULSE   = int'(SVGA_800x600_60.h_sp),
  parameter int unsigned H_BACK_PORCH   = int'(SVGA_800x600_60.h_bp),
  parameter int unsigned V_VISIBLE_AREA = int'(SVGA_800x600_60.v_vis),
  parameter int unsigned V_FRONT_PORCH  = int'(SVGA_800x600_60.v_fp),
  parameter int unsigned V_SYNC_PULSE   = int'(SVGA_800x600_60.v_sp),
  parameter int unsigned V_BACK_PORCH   = int'(SVGA_800x600_60.v_bp),
  parameter logic        HSYNC_POLARITY = SYNC_POS,
  parameter logic        VSYNC_POLARITY = SYNC_POS,
  parameter int unsigned PIPE_DELAY     = 0,
  parameter int unsigned CW             = 11,
  parameter int unsigned FCW            = 8
) (
  input  logic           VGA_CLK,
  input  logic           VGA_RST_N,
  input  logic           EN,
  output logic [CW-1:0]  PIX_X,
  output logic [CW-1:0]  PIX_Y,
  output logic           DE,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           LINE_START,
  output logic           FRAME_START,
  output logic [FCW-1:0] FRAME_COUNT
`ifdef VGA_TIMING_TEST_PATTERN_EN
  ,
  output logic [3:0]     VGA_R,
  output logic [3:0]     VGA_G,
  output logic [3:0]     VGA_B
`endif
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE_AREA, H_FRONT_PORCH,
                                               H_SYNC_PULSE, H_BACK_PORCH);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE_AREA, V_FRONT_PORCH,
                                               V_SYNC_PULSE, V_BACK_PORCH);
  localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if (H_VISIBLE_AREA == 0 || H_FRONT_PORCH == 0 || H_SYNC_PULSE == 0 ||
      H_BACK_PORCH == 0 || V_VISIBLE_AREA == 0 || V_FRONT_PORCH == 0 ||
      V_SYNC_PULSE == 0 || V_BACK_PORCH == 0 || CW == 0 || FCW == 0)
  begin : g_chk_min
    $error("vga_timing_gen: every timing and width parameter must be >= 1");
  end
  if (PIPE_DELAY > 15) begin : g_chk_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 0..15");
  end
  if ((64'd1 << CW) <= 64'(MAX_TOTAL)) begin : g_chk_width
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END = CW'(H_VISIBLE_AREA);
  localparam logic [CW-1:0] V_VIS_END = CW'(V_VISIBLE_AREA);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [CW-1:0] HS_STOP  = CW'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [CW-1:0] VS_STOP  = CW'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

  typedef struct packed {
    logic [CW-1:0]  pix_x;
    logic [CW-1:0]  pix_y;
    logic           de;
    logic           hs;
    logic           vs;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_count;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0]    rgb;
`endif
  } out_t;

  function automatic out_t idle_bundle();
    out_t b;
    b    = '0;
    b.hs = HSYNC_POLARITY;
    b.vs = VSYNC_POLARITY;
    return b;
  endfunction

  localparam out_t IDLE = idle_bundle();

  logic [CW-1:0]  h_cnt;
  logic [CW-1:0]  v_cnt;
  logic [FCW-1:0] frame_cnt;
  out_t           pre;
  out_t           stage0;
  out_t           delayed;

  // The frame counter advances on the wrap, so the bundle evaluated at the
  // new (0,0) already carries the incremented count next to FRAME_START.
  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (EN) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + FCW'(1);
        end else begin
          v_cnt <= v_cnt + CW'(1);
        end
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_VISIBLE_AREA / 8 == 0) ? 1 : H_VISIBLE_AREA / 8;

  // Bars 0..6 are BAR_W wide; bar 7 takes whatever is left of the line.
  logic [2:0] bar_idx;
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (32'(h_cnt) >= 32'(i) * BAR_W) begin
        bar_idx = 3'(i);
      end
    end
  end
`endif

  // While stopped the pixel coordinates keep their last value; everything
  // else presents the idle raster.
  always_comb begin
    pre             = stage0;
    pre.de          = 1'b0;
    pre.hs          = HSYNC_POLARITY;
    pre.vs          = VSYNC_POLARITY;
    pre.line_start  = 1'b0;
    pre.frame_start = 1'b0;
    pre.frame_count = frame_cnt;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    pre.rgb         = '0;
`endif
    if (EN) begin
      pre.de          = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
      pre.pix_x       = pre.de ? h_cnt : '0;
      pre.pix_y       = pre.de ? v_cnt : '0;
      pre.hs          = (h_cnt >= HS_START && h_cnt < HS_STOP) ? ~HSYNC_POLARITY
                                                               : HSYNC_POLARITY;
      pre.vs          = (v_cnt >= VS_START && v_cnt < VS_STOP) ? ~VSYNC_POLARITY
                                                               : VSYNC_POLARITY;
      pre.line_start  = (h_cnt == '0);
      pre.frame_start = (h_cnt == '0) && (v_cnt == '0);
`ifdef VGA_TIMING_TEST_PATTERN_EN
      pre.rgb         = pre.de ? BAR_RGB[bar_idx] : 12'h000;
`endif
    end
  end

  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      stage0 <= IDLE;
    end else begin
      stage0 <= pre;
    end
  end

  vga_delay_line #(
    .WIDTH       ($bits(out_t)),
    .DEPTH       (PIPE_DELAY),
    .RESET_VALUE (IDLE)
  ) u_delay (
    .clk   (VGA_CLK),
    .rst_n (VGA_RST_N),
    .din   (stage0),
    .dout  (delayed)
  );

  assign PIX_X       = delayed.pix_x;
  assign PIX_Y       = delayed.pix_y;
  assign DE          = delayed.de;
  assign VGA_HS      = delayed.hs;
  assign VGA_VS      = delayed.vs;
  assign LINE_START  = delayed.line_start;
  assign FRAME_START = delayed.frame_start;
  assign FRAME_COUNT = delayed.frame_count;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  assign VGA_R       = delayed.rgb[11:8];
  assign VGA_G       = delayed.rgb[7:4];
  assign VGA_B       = delayed.rgb[3:0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small mode, against a raster model
// that walks (h, v, frame) arithmetically and delays its outputs in a queue.
module tb_vga_timing_gen;

  localparam int HV = 20, HF = 3, HSP = 4, HB = 5;
  localparam int VV = 6,  VF = 2, VSP = 3, VB = 2;
  localparam int HT = HV + HF + HSP + HB;
  localparam int VT = VV + VF + VSP + VB;
  localparam int FT = HT * VT;
  localparam logic HP = 1'b1;
  localparam logic VP = 1'b0;
  localparam int PD  = 2;
  localparam int CW  = 6;
  localparam int FCW = 3;
  localparam int GAP = 10;

  logic clk, rst_n, en;
  logic [CW-1:0]  PIX_X, PIX_Y;
  logic           DE, VGA_HS, VGA_VS, LINE_START, FRAME_START;
  logic [FCW-1:0] FRAME_COUNT;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [3:0]     VGA_R, VGA_G, VGA_B;
`endif

  vga_timing_gen #(
    .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HB),
    .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VB),
    .HSYNC_POLARITY(HP), .VSYNC_POLARITY(VP), .PIPE_DELAY(PD), .CW(CW), .FCW(FCW)
  ) dut (
    .VGA_CLK(clk), .VGA_RST_N(rst_n), .EN(en),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .DE(DE), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START), .FRAME_COUNT(FRAME_COUNT)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  typedef struct packed {
    logic [CW-1:0]  px;
    logic [CW-1:0]  py;
    logic           de, hs, vs, ls, fs;
    logic [FCW-1:0] fc;
    logic [11:0]    rgb;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  exp_t exp_now;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_en = 0;

  int m_h, m_v, m_fc, held_px, held_py;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e    = '0;
    e.hs = HP;
    e.vs = VP;
    return e;
  endfunction

  function automatic logic [11:0] bar_colour(input int h);
    int   bar;
    logic [2:0] rgb_bits;
    logic [2:0] table_bits [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                   3'b101, 3'b100, 3'b001, 3'b000};
    bar = h / (HV / 8);
    if (bar > 7) bar = 7;
    rgb_bits = table_bits[bar];
    return {{4{rgb_bits[2]}}, {4{rgb_bits[1]}}, {4{rgb_bits[0]}}};
  endfunction

  function automatic exp_t model_eval(input logic en_i);
    exp_t e;
    e    = idle_exp();
    e.px = CW'(held_px);
    e.py = CW'(held_py);
    e.fc = FCW'(m_fc);
    if (en_i) begin
      e.de  = (m_h < HV) && (m_v < VV);
      e.px  = e.de ? CW'(m_h) : '0;
      e.py  = e.de ? CW'(m_v) : '0;
      e.hs  = (m_h >= HV + HF && m_h < HV + HF + HSP) ? ~HP : HP;
      e.vs  = (m_v >= VV + VF && m_v < VV + VF + VSP) ? ~VP : VP;
      e.ls  = (m_h == 0);
      e.fs  = (m_h == 0) && (m_v == 0);
      e.rgb = e.de ? bar_colour(m_h) : 12'h000;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t b;
    cyc++;
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_fc = 0; held_px = 0; held_py = 0;
      exp_q.delete();
      for (int i = 0; i < PD; i++) exp_q.push_back(idle_exp());
      exp_now = idle_exp();
    end else begin
      b = model_eval(en);
      held_px = int'(b.px);
      held_py = int'(b.py);
      if (en) begin
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v++;
          if (m_v == VT) begin
            m_v = 0;
            m_fc++;
          end
        end
      end
      exp_q.push_back(b);
      exp_now = exp_q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pix_x", PIX_X, exp_now.px);
      check("pix_y", PIX_Y, exp_now.py);
      check("de", DE, exp_now.de);
      check("hs", VGA_HS, exp_now.hs);
      check("vs", VGA_VS, exp_now.vs);
      check("line_start", LINE_START, exp_now.ls);
      check("frame_start", FRAME_START, exp_now.fs);
      check("frame_count", FRAME_COUNT, exp_now.fc);
`ifdef VGA_TIMING_TEST_PATTERN_EN
      check("rgb", {VGA_R, VGA_G, VGA_B}, exp_now.rgb);
`endif
    end
  end

  // driver tasks
  task automatic wait_frame_start(input int limit, output int n, output bit found);
    found = 0;
    n = 0;
    while (!found && n < limit) begin
      @(negedge clk);
      n++;
      if (FRAME_START) found = 1;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_de"}, DE, 1'b0);
    check({tag, "_hs"}, VGA_HS, HP);
    check({tag, "_vs"}, VGA_VS, VP);
    check({tag, "_fs"}, FRAME_START, 1'b0);
    check({tag, "_ls"}, LINE_START, 1'b0);
    check({tag, "_fc"}, FRAME_COUNT, '0);
    check({tag, "_px"}, PIX_X, '0);
    check({tag, "_py"}, PIX_Y, '0);
  endtask

  initial begin
    int  n, t0, de_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt;
    bit  found;

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk_en = 1;

    // release: first FRAME_START after 1+PD enabled edges
    rst_n = 1'b1;
    en    = 1'b1;
    wait_frame_start(50, n, found);
    check("startup_found", found, 1'b1);
    check("startup_latency", n, PD + 1);

    // one full frame of output statistics
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < FT; i++) begin
      de_cnt += int'(DE);
      hs_cnt += int'(VGA_HS == ~HP);
      vs_cnt += int'(VGA_VS == ~VP);
      ls_cnt += int'(LINE_START);
      fs_cnt += int'(FRAME_START);
      @(negedge clk);
    end
    check("de_per_frame", de_cnt, HV * VV);
    check("hs_per_frame", hs_cnt, HSP * VT);
    check("vs_per_frame", vs_cnt, VSP * HT);
    check("ls_per_frame", ls_cnt, VT);
    check("fs_per_frame", fs_cnt, 1);
    check("frame_period", FRAME_START, 1'b1);
    t0 = cyc;

    // run-enable gap in the middle of a visible line
    found = 0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      @(negedge clk);
      if (DE && PIX_X == 4 && PIX_Y == 2) found = 1;
    end
    check("gap_pos_found", found, 1'b1);
    en = 1'b0;
    repeat (GAP) @(negedge clk);
    check("gap_de_low", DE, 1'b0);
    check("gap_hs_idle", VGA_HS, HP);
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (DE) found = 1;
    end
    check("resume_found", found, 1'b1);
    check("resume_px", PIX_X, CW'(4 + PD + 1));
    check("resume_py", PIX_Y, CW'(2));
    wait_frame_start(2 * FT, n, found);
    check("gap_fs_found", found, 1'b1);
    check("gap_frame_period", cyc - t0, FT + GAP);

    // random run-enable pattern
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
    end
    en = 1'b1;

    // asynchronous reset mid-frame
    found = 0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      @(negedge clk);
      if (DE && PIX_Y == 3) found = 1;
    end
    check("midreset_pos_found", found, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame_start(50, n, found);
    check("rerun_found", found, 1'b1);
    check("rerun_latency", n, PD + 1);
    check("rerun_fc", FRAME_COUNT, '0);

    // enough frames to wrap the frame counter
    repeat (9 * FT) @(negedge clk);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed-mode VGA test block. Generates horizontal and vertical timing for any mode from porch, sync and visible parameters, with per-axis sync polarity. Outputs pixel coordinates, data-enable, line/frame strobes and a frame counter. A configurable delay line aligns all outputs with a downstream pixel pipeline. Sits between the pixel clock and the DE10-Lite VGA pins or the framebuffer reader.

Parameters:
- H_VISIBLE_AREA, 800, visible pixels per line
- H_FRONT_PORCH, 40, clocks after the visible area
- H_SYNC_PULSE, 128, HS active clocks
- H_BACK_PORCH, 88, clocks after HS
- V_VISIBLE_AREA, 600, visible lines
- V_FRONT_PORCH, 1, lines
- V_SYNC_PULSE, 4, lines
- V_BACK_PORCH, 23, lines
- HSYNC_POLARITY, 1'b0, 0 = positive pulse (idle low), 1 = negative pulse (idle high)
- VSYNC_POLARITY, 1'b0, same convention for VS
- PIPE_DELAY, 0, extra register stages on all outputs (0..15)
- CW, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FCW, 8, frame counter width

Ports:
- VGA_CLK  in  1  pixel clock
- VGA_RST_N  in  1  asynchronous active-low reset
- EN  in  1  run enable; 0 freezes the raster
- PIX_X  out  CW  visible column, 0..H_VISIBLE_AREA-1; 0 outside the visible area
- PIX_Y  out  CW  visible row; 0 outside the visible area
- DE  out  1  high during visible pixels
- VGA_HS  out  1  horizontal sync, polarity per parameter
- VGA_VS  out  1  vertical sync, polarity per parameter
- LINE_START  out  1  one-clock pulse at h=0
- FRAME_START  out  1  one-clock pulse at h=0, v=0
- FRAME_COUNT  out  FCW  frames completed, wraps modulo 2^FCW

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
  - Default mode: 1056 x 628 clocks.
  - At 40 MHz one frame is 663,168 clocks = 16,579,200 ns.
- Counter h: increments each clock while EN=1. At H_TOTAL-1 it wraps to 0 and v increments.
- Counter v: wraps from V_TOTAL-1 to 0. FRAME_COUNT increments on that wrap.
- Segment order per axis: visible, front porch, sync, back porch.
  - HS active for h in [H_VIS+H_FP, H_VIS+H_FP+H_SP-1].
  - VS active for v in [V_VIS+V_FP, V_VIS+V_FP+V_SP-1]; VS switches at h=0 of the line.
  - Active level = ~POLARITY; idle level = POLARITY.
- DE = (h < H_VIS) && (v < V_VIS).
- Latency: every output is registered and appears 1+PIPE_DELAY clocks after the counter state that produced it. All outputs stay mutually aligned; the delay line covers every output.
- EN=0:
  - Counters and FRAME_COUNT hold.
  - Combinational pre-delay values become DE=0, syncs idle, strobes 0, PIX_X/PIX_Y held.
  - Values already in the delay line drain normally.
  - On EN rising, the raster resumes from the held position; no strobe is re-issued.
- Reset (asynchronous, any time, including mid-frame):
  - h, v, FRAME_COUNT, PIX_X, PIX_Y, DE and strobes go to 0.
  - VGA_HS = HSYNC_POLARITY, VGA_VS = VSYNC_POLARITY.
  - All delay-line stages are cleared to these same idle values.
  - The first clock after release with EN=1 evaluates h=0, v=0. FRAME_START then appears 1+PIPE_DELAY clocks later.
- FRAME_COUNT increments together with FRAME_START of the new frame (same output cycle). It reads 1 at the first wrap after reset.
- Compile-time checks: every parameter ≥1; PIPE_DELAY ≤15; 2^CW > max(H_TOTAL, V_TOTAL). A violation triggers an elaboration error.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- Defined:
  - Adds outputs VGA_R, VGA_G, VGA_B, 4 bits each, aligned with DE.
  - Eight vertical colour bars, each H_VISIBLE_AREA/8 wide (last bar absorbs the remainder). Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Channel value 4'hF or 4'h0; all channels 0 when DE=0 and in reset.
- Undefined: the ports do not exist and no pattern logic is built.

Decomposition:
- Package vga_timing_pkg:
  - Mode constant sets SVGA_800x600_60 (40 MHz, the defaults) and VESA_800x600_72 (50 MHz: 800/56/120/64, 600/37/6/23, positive syncs).
  - Function computing totals.
  - Polarity encoding constants.
  - Bar colour table.
- Sub-module vga_delay_line:
  - Parameters WIDTH, DEPTH and RESET_VALUE.
  - Asynchronous active-low reset.
  - DEPTH=0 is a pass-through.
  - Instantiated once on the packed output bundle.

Test Plan:
- Defaults, PIPE_DELAY=0, EN=1, 40 MHz: HS pulses exactly 128 clocks high every 1056 clocks. VS is high for 4 lines (4224 clocks). FRAME_START period is 663,168 clocks. DE count per frame = 480,000.
- HSYNC_POLARITY=1, VSYNC_POLARITY=1: HS/VS idle high during and after reset and pulse low. Edge positions are identical to the positive case.
- PIPE_DELAY=3: every output transition occurs exactly 3 clocks later than with PIPE_DELAY=0 for the same stimulus. Outputs are idle for the first 4 clocks after reset release.
- EN dropped at h=500, v=10 for 100 clocks: DE=0 and syncs idle during the gap. On resume PIX_X=500 and PIX_Y=10; the frame period is lengthened by exactly 100.
- Reset asserted mid-frame (v=300): outputs go idle asynchronously. After release, FRAME_COUNT=0, and the first FRAME_START arrives 1+PIPE_DELAY clocks after the first enabled edge.
- Test pattern enabled, defaults: on line 0, x=0 gives RGB=FFF, x=100 gives FF0, x=799 gives 000. At x=800 (DE=0) all channels are 0.
